// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer built around one shared
// 1-bit full_adder cell. Operands are accepted over an in_valid/in_ready
// handshake, added LSB first over WIDTH cycles, and the result is offered
// over an out_valid/out_ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand request valid
//   in_ready   controller idle and able to accept operands
//   op_a/op_b  WIDTH-bit operands, sampled only on the acceptance edge
//   cin        carry-in, sampled only on the acceptance edge
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   sum/cout   result; meaningful only while out_valid=1
//   busy       high while an operation is running or waiting for handshake

// full_adder: combinational 1-bit full adder cell.
//   a, b, ci  addend bits and carry-in
//   s, co     sum bit and carry-out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic            c_reg, cout_r;
    logic [CW-1:0]   cnt;
    logic            fa_s, fa_c;
    logic            accept, last;

    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (c_reg),
        .s  (fa_s),
        .co (fa_c)
    );

    assign accept = (state == S_IDLE) && in_valid;
    assign last   = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sum bits enter at the MSB so that after WIDTH shifts the first
    // (LSB) bit has walked down to bit 0. The counter stops at WIDTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            c_reg  <= 1'b0;
            cout_r <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr  <= op_a;
            b_sr  <= op_b;
            c_reg <= cin;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {fa_s, res_sr[WIDTH-1:1]};
            c_reg  <= fa_c;
            if (last) begin
                cout_r <= fa_c;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign sum  = res_sr;
    assign cout = cout_r;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 (dut0) and WIDTH=2
// (dut1). Expected results are pushed on acceptance and popped when the
// DUT presents a result.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dut0, WIDTH=8
    logic       iv0 = 1'b0, ir0, ov0, or0 = 1'b0, ci0 = 1'b0, co0, bz0;
    logic [7:0] a0 = '0, b0 = '0, s0;
    // dut1, WIDTH=2
    logic       iv1 = 1'b0, ir1, ov1, or1 = 1'b0, ci1 = 1'b0, co1, bz1;
    logic [1:0] a1 = '0, b1 = '0, s1;

    serial_add_ctrl #(.WIDTH(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
        .op_a(a0), .op_b(b0), .cin(ci0), .out_valid(ov0), .out_ready(or0),
        .sum(s0), .cout(co0), .busy(bz0)
    );
    serial_add_ctrl #(.WIDTH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .op_a(a1), .op_b(b1), .cin(ci1), .out_valid(ov1), .out_ready(or1),
        .sum(s1), .cout(co1), .busy(bz1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] sbq[$];
    int acc_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic f_ov(input int d);
        return (d == 0) ? ov0 : ov1;
    endfunction
    function automatic logic f_ir(input int d);
        return (d == 0) ? ir0 : ir1;
    endfunction
    function automatic logic f_bz(input int d);
        return (d == 0) ? bz0 : bz1;
    endfunction
    function automatic logic [8:0] f_res(input int d);
        return (d == 0) ? {co0, s0} : {6'b0, co1, s1};
    endfunction

    task automatic set_ordy(input int d, input logic v);
        if (d == 0) or0 = v; else or1 = v;
    endtask
    task automatic set_ops(input int d, input logic [7:0] a, input logic [7:0] b, input logic ci);
        if (d == 0) begin a0 = a; b0 = b; ci0 = ci; end
        else begin a1 = a[1:0]; b1 = b[1:0]; ci1 = ci; end
    endtask
    task automatic set_iv(input int d, input logic v);
        if (d == 0) iv0 = v; else iv1 = v;
    endtask

    // Present an operand set, wait for in_ready, accept on the next edge.
    task automatic accept_op(input int d, input logic [7:0] a, input logic [7:0] b,
                             input logic ci, input bit keep);
        int n;
        logic [7:0] m;
        n = 0;
        set_ops(d, a, b, ci);
        set_iv(d, 1'b1);
        while (!f_ir(d) && n < 200) begin @(posedge clk); #1; n++; end
        chk("accept_timeout", 32'(n < 200), 32'd1);
        m = (d == 0) ? 8'hFF : 8'h03;
        @(posedge clk); #1;
        acc_cyc = cyc;
        sbq.push_back({1'b0, a & m} + {1'b0, b & m} + {8'b0, ci});
        if (!keep) set_iv(d, 1'b0);
    endtask

    // Wait for out_valid, check latency and value, stall, then handshake.
    task automatic get_result(input int d, input int stall, output int nb);
        int n;
        logic [8:0] expv;
        n = 0;
        nb = int'(f_bz(d));
        while (!f_ov(d) && n < 100) begin
            @(posedge clk); #1; n++;
            nb += int'(f_bz(d));
        end
        chk("result_timeout", 32'(f_ov(d)), 32'd1);
        if (!f_ov(d)) return;
        chk("latency", 32'(cyc - acc_cyc), (d == 0) ? 32'd8 : 32'd2);
        if (sbq.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
            expv = '0;
        end else begin
            expv = sbq.pop_front();
        end
        chk("result", 32'(f_res(d)), 32'(expv));
        set_ordy(d, stall == 0);
        repeat (stall) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(f_ov(d)), 32'd1);
            chk("hold_result", 32'(f_res(d)), 32'(expv));
            chk("hold_in_ready", 32'(f_ir(d)), 32'd0);
        end
        set_ordy(d, 1'b1);
        @(posedge clk); #1;
        chk("valid_drop", 32'(f_ov(d)), 32'd0);
    endtask

    initial begin
        int nb, nv;

        // Reset held across three edges.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_busy", 32'(bz0), 32'd0);
        chk("rst_result", 32'(f_res(0)), 32'd0);
        chk("rst_in_ready", 32'(ir0), 32'd1);
        rst_n = 1'b1;

        // Asynchronous reset mid-RUN takes effect before any edge.
        set_ordy(0, 1'b1);
        accept_op(0, 8'hA5, 8'h0F, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(ov0), 32'd0);
        chk("async_busy", 32'(bz0), 32'd0);
        chk("async_result", 32'(f_res(0)), 32'd0);
        chk("async_in_ready", 32'(ir0), 32'd1);
        sbq.delete();
        #3 rst_n = 1'b1;

        // Basic add, out_ready already high: one-cycle out_valid.
        @(posedge clk); #1;
        accept_op(0, 8'h5A, 8'h33, 1'b0, 1'b0);
        get_result(0, 0, nb);
        chk("busy_cycles", 32'(nb), 32'd9);
        chk("busy_after", 32'(bz0), 32'd0);

        // Carry chain.
        accept_op(0, 8'hFF, 8'h01, 1'b0, 1'b0); get_result(0, 0, nb);
        accept_op(0, 8'hFF, 8'h00, 1'b1, 1'b0); get_result(0, 0, nb);
        accept_op(0, 8'h00, 8'h00, 1'b0, 1'b0); get_result(0, 0, nb);

        // Backpressure with a competing request held throughout.
        accept_op(0, 8'h80, 8'h80, 1'b0, 1'b1);
        set_ops(0, 8'h11, 8'h22, 1'b0);
        get_result(0, 5, nb);
        chk("bp_not_accepted", 32'(bz0), 32'd0);
        chk("bp_in_ready", 32'(ir0), 32'd1);
        accept_op(0, 8'h11, 8'h22, 1'b0, 1'b0);
        get_result(0, 0, nb);

        // Operand change during RUN is ignored.
        accept_op(0, 8'h12, 8'h34, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        set_ops(0, 8'hFF, 8'hFF, 1'b1);
        get_result(0, 0, nb);

        // Reset on RUN cycle 3 abandons the operation.
        accept_op(0, 8'h77, 8'h11, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        sbq.delete();
        nv = 0;
        repeat (11) begin @(posedge clk); #1; nv += int'(ov0); end
        chk("abandoned_no_valid", 32'(nv), 32'd0);
        accept_op(0, 8'h01, 8'h02, 1'b0, 1'b0);
        get_result(0, 0, nb);

        // Random traffic on both widths.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 200; i++) begin
                set_ordy(d, 1'($urandom_range(0, 1)));
                accept_op(d, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
                get_result(d, int'($urandom_range(0, 3)), nb);
            end
        end

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
